// File: rtl/button_conditioner.sv
// N-channel push-button front end: 2-FF synchroniser, counter debouncer, press/release strobes
// and optional hold-to-repeat. The release strobe port is named release_pulse ("release" is a
// reserved word in SystemVerilog).
module button_conditioner #(
    parameter int unsigned  N             = 3,
    parameter int unsigned  DB_CYCLES     = 16,
    parameter int unsigned  REPEAT_DELAY  = 50_000_000,
    parameter int unsigned  REPEAT_PERIOD = 10_000_000,
    parameter logic [N-1:0] REPEAT_MASK   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] rpt,
    output logic         any_press
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TW = $clog2(RMAX + 1);
    localparam logic [TW-1:0] DELAY_T  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] PERIOD_T = TW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {StIdle, StWait, StRpt} rpt_state_e;

    logic [N-1:0] rise_all;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic          s1, s2, lvl, lvl_next;
        logic [CW-1:0] cnt;
        logic          rise, fall;
        logic          press_q, release_q, rpt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= btn_in[i];
                s2 <= s1;
            end
        end

        // Level flips only after DB_CYCLES consecutive disagreeing samples.
        always_comb begin
            lvl_next = lvl;
            if (s2 != lvl && cnt == DB_LAST) lvl_next = s2;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl <= 1'b0;
                cnt <= '0;
            end else begin
                lvl <= lvl_next;
                if (s2 == lvl || cnt == DB_LAST) cnt <= '0;
                else                             cnt <= cnt + CW'(1);
            end
        end

        assign rise = lvl_next & ~lvl;
        assign fall = ~lvl_next & lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= rise;
                release_q <= fall;
            end
        end

        if (REPEAT_MASK[i]) begin : g_rpt
            rpt_state_e    state;
            logic [TW-1:0] tmr;

            // Timer is 1 on the cycle after entry so rpt lands exactly DELAY/PERIOD edges later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= StIdle;
                    tmr   <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    if (fall) begin
                        state <= StIdle;
                        tmr   <= '0;
                    end else begin
                        case (state)
                            StIdle: begin
                                if (rise) begin
                                    state <= StWait;
                                    tmr   <= TW'(1);
                                end
                            end
                            StWait: begin
                                if (tmr == DELAY_T) begin
                                    rpt_q <= 1'b1;
                                    state <= StRpt;
                                    tmr   <= TW'(1);
                                end else begin
                                    tmr <= tmr + TW'(1);
                                end
                            end
                            StRpt: begin
                                if (tmr == PERIOD_T) begin
                                    rpt_q <= 1'b1;
                                    tmr   <= TW'(1);
                                end else begin
                                    tmr <= tmr + TW'(1);
                                end
                            end
                            default: begin
                                state <= StIdle;
                                tmr   <= '0;
                            end
                        endcase
                    end
                end
            end
        end else begin : g_no_rpt
            assign rpt_q = 1'b0;
        end

        assign level[i]         = lvl;
        assign press[i]         = press_q;
        assign release_pulse[i] = release_q;
        assign rpt[i]           = rpt_q;
        assign rise_all[i]      = rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_press <= 1'b0;
        else        any_press <= |rise_all;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: N=3, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3,
// repeat enabled on channel 2 only.
module tb_button_conditioner;

    localparam int unsigned N = 3;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] level, press, release_pulse, rpt;
    logic         any_press;

    int vectors     = 0;
    int miscompares = 0;

    logic [N-1:0] exp_lvl, exp_rel, exp_rpt;

    always #5 clk = ~clk;

    button_conditioner #(
        .N            (N),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3),
        .REPEAT_MASK  (3'b100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .rpt          (rpt),
        .any_press    (any_press)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] e_lvl, input logic [N-1:0] e_prs,
                           input logic [N-1:0] e_rel, input logic [N-1:0] e_rpt, input logic e_any);
        chk({tag, ".level"}, level, e_lvl);
        chk({tag, ".press"}, press, e_prs);
        chk({tag, ".release"}, release_pulse, e_rel);
        chk({tag, ".rpt"}, rpt, e_rpt);
        chk({tag, ".any_press"}, N'(any_press), N'(e_any));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_all("reset", '0, '0, '0, '0, 1'b0);
        #3 rst_n = 1'b1;
        repeat (3) begin
            tick();
            chk_all("idle", '0, '0, '0, '0, 1'b0);
        end

        // 1: clean press and release on channel 0, long hold without repeat
        btn_in = 3'b001;
        repeat (5) begin
            tick();
            chk_all("t1_wait", '0, '0, '0, '0, 1'b0);
        end
        tick();
        chk_all("t1_press", 3'b001, 3'b001, '0, '0, 1'b1);
        repeat (15) begin
            tick();
            chk_all("t1_hold", 3'b001, '0, '0, '0, 1'b0);
        end
        btn_in = 3'b000;
        repeat (5) begin
            tick();
            chk_all("t1_rwait", 3'b001, '0, '0, '0, 1'b0);
        end
        tick();
        chk_all("t1_release", '0, '0, 3'b001, '0, 1'b0);
        tick();
        chk_all("t1_after", '0, '0, '0, '0, 1'b0);

        // 2: bouncing channel 1 never reaches level
        btn_in[1] = 1'b1;
        repeat (3) begin tick(); chk_all("t2_bounce", '0, '0, '0, '0, 1'b0); end
        btn_in[1] = 1'b0;
        tick();
        chk_all("t2_bounce", '0, '0, '0, '0, 1'b0);
        btn_in[1] = 1'b1;
        repeat (2) begin tick(); chk_all("t2_bounce", '0, '0, '0, '0, 1'b0); end
        btn_in[1] = 1'b0;
        repeat (12) begin tick(); chk_all("t2_bounce", '0, '0, '0, '0, 1'b0); end

        // 3: auto-repeat on channel 2, channel 1 held alongside without repeat
        btn_in = 3'b110;
        repeat (5) begin
            tick();
            chk_all("t3_wait", '0, '0, '0, '0, 1'b0);
        end
        tick();
        chk_all("t3_press", 3'b110, 3'b110, '0, '0, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp_lvl = (k < 17) ? 3'b110 : 3'b000;
            exp_rel = (k == 17) ? 3'b110 : 3'b000;
            exp_rpt = (k == 10 || k == 13 || k == 16) ? 3'b100 : 3'b000;
            chk_all($sformatf("t3_k%0d", k), exp_lvl, '0, exp_rel, exp_rpt, 1'b0);
            if (k == 11) btn_in = 3'b000;
        end

        // 4: release accepted on a scheduled repeat edge
        btn_in = 3'b100;
        repeat (5) begin
            tick();
            chk_all("t4_wait", '0, '0, '0, '0, 1'b0);
        end
        tick();
        chk_all("t4_press", 3'b100, 3'b100, '0, '0, 1'b1);
        for (int k = 1; k <= 25; k++) begin
            tick();
            exp_lvl = (k < 19) ? 3'b100 : 3'b000;
            exp_rel = (k == 19) ? 3'b100 : 3'b000;
            exp_rpt = (k == 10 || k == 13 || k == 16) ? 3'b100 : 3'b000;
            chk_all($sformatf("t4_k%0d", k), exp_lvl, '0, exp_rel, exp_rpt, 1'b0);
            if (k == 13) btn_in = 3'b000;
        end

        // 5: simultaneous press on all channels; first repeat proves FSM restarted from idle
        btn_in = 3'b111;
        repeat (5) begin
            tick();
            chk_all("t5_wait", '0, '0, '0, '0, 1'b0);
        end
        tick();
        chk_all("t5_press", 3'b111, 3'b111, '0, '0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_rpt = (k == 10) ? 3'b100 : 3'b000;
            chk_all($sformatf("t5_k%0d", k), 3'b111, '0, '0, exp_rpt, 1'b0);
        end

        // 6: asynchronous reset mid-repeat, buttons held through deassertion
        #3 rst_n = 1'b0;
        #1;
        chk_all("t6_async", '0, '0, '0, '0, 1'b0);
        repeat (2) begin
            tick();
            chk_all("t6_inreset", '0, '0, '0, '0, 1'b0);
        end
        #3 rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_all($sformatf("t6_e%0d", e), '0, '0, '0, '0, 1'b0);
        end
        tick();
        chk_all("t6_press", 3'b111, 3'b111, '0, '0, 1'b1);
        for (int e = 7; e <= 18; e++) begin
            tick();
            exp_rpt = (e == 16) ? 3'b100 : 3'b000;
            chk_all($sformatf("t6_e%0d", e), 3'b111, '0, '0, exp_rpt, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised N-channel push-button front end that turns raw, bouncing, asynchronous button levels into clean per-channel control strobes. Each channel gets a 2-FF synchroniser, a counter-based debouncer, one-cycle press and release pulses, and an optional hold-to-repeat strobe. It sits between the board buttons and the Sudoku control logic: reset, start and enter today, with room for cursor-move buttons that need auto-repeat.

## Interface
- N, 3: number of button channels (≥1).
- DB_CYCLES, 16: consecutive stable cycles required to accept a level change (≥1).
- REPEAT_DELAY, 50_000_000: cycles from press to first repeat strobe (≥2).
- REPEAT_PERIOD, 10_000_000: cycles between subsequent repeat strobes (≥1).
- REPEAT_MASK, {N{1'b0}}: per-channel auto-repeat enable; bit i = 1 enables channel i.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  N  raw button levels, asynchronous, 1 = pressed.
- level  out  N  debounced, synchronised button level.
- press  out  N  one-cycle strobe on each accepted 0→1 of level.
- release  out  N  one-cycle strobe on each accepted 1→0 of level.
- rpt  out  N  one-cycle auto-repeat strobe while held; masked channels always 0.
- any_press  out  1  OR of press, registered alongside press.

## Operation
- Per channel, identical and independent. No cross-channel priority; simultaneous events on different channels all appear in the same cycle.
- Synchroniser: s1 <= btn_in[i], s2 <= s1.
- Debounce counter, width $clog2(DB_CYCLES+1):
  - s2 == level: cnt <= 0.
  - s2 != level and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s2 != level and cnt == DB_CYCLES-1: level <= s2, cnt <= 0.
- A glitch shorter than DB_CYCLES cycles at s2 clears the counter and never reaches level. Counting restarts from 0 after every disagreement break.
- press/release are registered: press <= next_level & ~level, release <= ~next_level & level. Each is high in the same cycle that level shows its new value.
- Repeat FSM per channel, timer width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE: on press → WAIT, timer <= 1.
  - WAIT: timer increments each cycle. When timer == REPEAT_DELAY: assert rpt and go → RPT with timer <= 1.
  - RPT: timer increments each cycle. When timer == REPEAT_PERIOD: assert rpt and set timer <= 1.
  - Any state: release → IDLE, timer <= 0, no rpt that cycle. Release wins over a coincident repeat.
  - REPEAT_MASK[i] = 0: FSM held in IDLE and rpt[i] = 0.
- Reset:
  - All s1, s2, cnt, level, press, release, rpt, any_press, timers and FSMs go to 0/IDLE immediately on rst_n low.
  - Reset mid-bounce or mid-repeat discards all progress.
  - A button already held when rst_n deasserts is treated as a fresh press: level rises DB_CYCLES+2 edges later with a press strobe.

## Timing
- btn_in stable at the new value from sampling edge t → level and press/release update at edge t+DB_CYCLES+1. Total latency is DB_CYCLES+2 edges, counting edge t.
- Press at edge p: rpt at edges p+REPEAT_DELAY, then p+REPEAT_DELAY+k·REPEAT_PERIOD for k ≥ 1, for as long as level = 1.
- All outputs are registered. No combinational path from btn_in to any output.
- press and rpt never coincide: press occurs only on entry to WAIT.
- Minimum accepted toggle interval is DB_CYCLES cycles. Shorter pulses are filtered.

## Test plan
Bench parameters: N=3, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=3'b100.

1. Clean press: btn_in[0] 0→1 at edge 5, held → level[0] = 1 and press[0] = any_press = 1 for exactly one cycle at edge 10. Release at edge 30 → release[0] pulse at edge 35.
2. Bounce: btn_in[1] high for 3 cycles, low for 1, high for 2, then low → level[1], press[1] and release[1] remain 0 throughout.
3. Auto-repeat: btn_in[2] held, press at edge p → rpt[2] at p+10, p+13, p+16. Release accepted at edge p+17 → no further rpt. rpt[0] and rpt[1] stay 0 during long holds.
4. Release/repeat collision: arrange the release of channel 2 to be accepted exactly at a scheduled rpt edge → release[2] = 1, rpt[2] = 0 that cycle, FSM back in IDLE.
5. Simultaneous: all three buttons rise on the same edge → press = 3'b111 in one cycle, any_press = 1 for one cycle.
6. Async reset: rst_n pulled low mid-repeat and between clock edges → all outputs 0 immediately. btn_in[2] held through deassertion → press[2] at the 6th edge after rst_n rises, rpt[2] 10 edges later.
